// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM capture block and the PWM generator.
//
// Contents:
//   DEFAULT_TIMEOUT    cycles without a synchronized edge before a measurement is abandoned
//   REG_*              register indices, i.e. PADDR[3:2]
//   BLOCK_SEL          value of PADDR[11:8] that selects the block
//   CTRL_* / STATUS_*  field bit positions
//   pwm_state_e        capture FSM state encoding
//   sat_inc()          32-bit saturating increment used by the measurement counters

package pwm_pkg;

    localparam int unsigned DEFAULT_TIMEOUT = 2000000;

    // Register map (word index = PADDR[3:2])
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_HIGH   = 2'd2;
    localparam logic [1:0] REG_PERIOD = 2'd3;

    localparam logic [3:0] BLOCK_SEL = 4'h0;

    // CTRL fields
    localparam int unsigned CTRL_EN_BIT = 0;
    localparam int unsigned CTRL_IE_BIT = 1;

    // STATUS fields
    localparam int unsigned STATUS_VALID_BIT  = 0;
    localparam int unsigned STATUS_TMO_BIT    = 1;
    localparam int unsigned STATUS_ACTIVE_BIT = 2;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitRise = 2'd1,
        StHighPh   = 2'd2,
        StLowPh    = 2'd3
    } pwm_state_e;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: two-flop synchronizer for an asynchronous input followed by a
// third flop used for edge detection.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset, clears all three flops
//   async_in  asynchronous input signal
//   level     synchronized level (output of the second flop)
//   rise      single-cycle pulse on a synchronized 0->1 transition
//   fall      single-cycle pulse on a synchronized 1->0 transition

module pwm_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    // [0] and [1] form the synchronizer; [2] delays the synchronized level by one cycle.
    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_in};
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: APB-accessible PWM measurement block. Measures the high time and
// the period (rise to rise) of an asynchronous PWM input, in PCLK cycles.
//
// Parameters:
//   TIMEOUT     cycles without a synchronized edge before a measurement is abandoned
//   RESET_HIGH  reset value of the HIGH register
//
// Ports:
//   PCLK, PRESET                  clock (rising edge) and synchronous active-high reset
//   PSEL, PENABLE, PWRITE, PADDR,
//   PWDATA, PRDATA, PREADY,
//   PSLVERR                       APB slave; PRDATA registered, no wait states, no errors
//   pwm_in                        asynchronous PWM input
//   capture_irq                   level interrupt: IE & (VALID | TMO)
//
// Registers (index PADDR[3:2], block selected when PADDR[11:8] == 0):
//   0 CTRL    bit0 EN, bit1 IE                      RW
//   1 STATUS  bit0 VALID, bit1 TMO (W1C), bit2 ACTIVE (RO)
//   2 HIGH    last captured high time               RO
//   3 PERIOD  last captured period                  RO

module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT,
    parameter logic [31:0] RESET_HIGH = 32'd0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        pwm_in,
    output logic        capture_irq
);

    // ------------------------------------------------------------------
    // Input synchronizer and edge detector
    // ------------------------------------------------------------------
    logic pwm_level;
    logic pwm_rise;
    logic pwm_fall;

    pwm_edge_sync u_edge_sync (
        .clk      (PCLK),
        .rst      (PRESET),
        .async_in (pwm_in),
        .level    (pwm_level),
        .rise     (pwm_rise),
        .fall     (pwm_fall)
    );

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic       apb_hit;
    logic [1:0] reg_idx;
    logic       wr_en;
    logic       rd_setup;
    logic       wr_ctrl;
    logic       wr_status;

    assign apb_hit   = PSEL && (PADDR[11:8] == BLOCK_SEL);
    assign reg_idx   = PADDR[3:2];
    assign wr_en     = apb_hit && PENABLE && PWRITE;
    assign rd_setup  = PSEL && !PENABLE && !PWRITE;
    assign wr_ctrl   = wr_en && (reg_idx == REG_CTRL);
    assign wr_status = wr_en && (reg_idx == REG_STATUS);

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    pwm_state_e  state_q, state_d;
    logic [31:0] period_cnt_q, period_cnt_d;
    logic [31:0] high_cnt_q, high_cnt_d;

    logic        ctrl_en_q;
    logic        ctrl_ie_q;
    logic        valid_q, valid_d;
    logic        tmo_q, tmo_d;
    logic [31:0] high_reg_q;
    logic [31:0] period_reg_q;
    logic [31:0] prdata_q;

    logic        en_eff;
    logic        capture;
    logic        timeout;
    logic        active;

    // A CTRL write in the same cycle overrides the stored EN, so clearing EN
    // suppresses a capture that would otherwise land on the same edge.
    assign en_eff = wr_ctrl ? PWDATA[CTRL_EN_BIT] : ctrl_en_q;
    assign active = (state_q == StHighPh) || (state_q == StLowPh);

    // ------------------------------------------------------------------
    // Measurement FSM: next state and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        capture      = 1'b0;
        timeout      = 1'b0;

        if (!en_eff) begin
            state_d      = StIdle;
            period_cnt_d = 32'd0;
            high_cnt_d   = 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d      = StWaitRise;
                    period_cnt_d = 32'd0;
                    high_cnt_d   = 32'd0;
                end

                // period_cnt doubles as the "cycles without a rise" counter here.
                StWaitRise: begin
                    if (period_cnt_q >= TIMEOUT) begin
                        timeout      = 1'b1;
                        period_cnt_d = 32'd0;
                        high_cnt_d   = 32'd0;
                    end else if (pwm_rise) begin
                        state_d      = StHighPh;
                        period_cnt_d = 32'd1;
                        high_cnt_d   = 32'd1;
                    end else begin
                        period_cnt_d = sat_inc(period_cnt_q);
                    end
                end

                StHighPh: begin
                    if (period_cnt_q >= TIMEOUT) begin
                        timeout      = 1'b1;
                        state_d      = StWaitRise;
                        period_cnt_d = 32'd0;
                        high_cnt_d   = 32'd0;
                    end else if (pwm_fall) begin
                        // high_cnt already equals the synchronized high time.
                        state_d      = StLowPh;
                        period_cnt_d = sat_inc(period_cnt_q);
                    end else begin
                        period_cnt_d = sat_inc(period_cnt_q);
                        high_cnt_d   = sat_inc(high_cnt_q);
                    end
                end

                StLowPh: begin
                    if (period_cnt_q >= TIMEOUT) begin
                        timeout      = 1'b1;
                        state_d      = StWaitRise;
                        period_cnt_d = 32'd0;
                        high_cnt_d   = 32'd0;
                    end else if (pwm_rise) begin
                        capture      = 1'b1;
                        state_d      = StHighPh;
                        period_cnt_d = 32'd1;
                        high_cnt_d   = 32'd1;
                    end else begin
                        period_cnt_d = sat_inc(period_cnt_q);
                    end
                end

                default: begin
                    state_d      = StIdle;
                    period_cnt_d = 32'd0;
                    high_cnt_d   = 32'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // STATUS next state: a new event beats a same-cycle write-1-to-clear
    // ------------------------------------------------------------------
    always_comb begin
        valid_d = (valid_q & ~(wr_status & PWDATA[STATUS_VALID_BIT])) | capture;
        tmo_d   = (tmo_q & ~(wr_status & PWDATA[STATUS_TMO_BIT])) | timeout;
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] rd_data;

    always_comb begin
        rd_data = 32'd0;
        case (reg_idx)
            REG_CTRL: begin
                rd_data[CTRL_EN_BIT] = ctrl_en_q;
                rd_data[CTRL_IE_BIT] = ctrl_ie_q;
            end
            REG_STATUS: begin
                rd_data[STATUS_VALID_BIT]  = valid_q;
                rd_data[STATUS_TMO_BIT]    = tmo_q;
                rd_data[STATUS_ACTIVE_BIT] = active;
            end
            REG_HIGH:   rd_data = high_reg_q;
            REG_PERIOD: rd_data = period_reg_q;
            default:    rd_data = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= StIdle;
            period_cnt_q <= 32'd0;
            high_cnt_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_en_q    <= 1'b0;
            ctrl_ie_q    <= 1'b0;
            valid_q      <= 1'b0;
            tmo_q        <= 1'b0;
            high_reg_q   <= RESET_HIGH;
            period_reg_q <= 32'd0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en_q <= PWDATA[CTRL_EN_BIT];
                ctrl_ie_q <= PWDATA[CTRL_IE_BIT];
            end
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
            if (capture) begin
                high_reg_q   <= high_cnt_q;
                period_reg_q <= period_cnt_q;
            end
        end
    end

    // PRDATA is captured in the setup phase and held through the access phase.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            prdata_q <= 32'd0;
        end else if (rd_setup) begin
            prdata_q <= apb_hit ? rd_data : 32'd0;
        end
    end

    assign PRDATA      = prdata_q;
    assign capture_irq = ctrl_ie_q & (valid_q | tmo_q);

    // Address/data bits outside the decoded fields, and the raw level output.
    logic unused_bits;
    assign unused_bits = ^{PADDR[31:12], PADDR[7:4], PADDR[1:0], PWDATA[31:2], pwm_level};

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed, table-driven bench for pwm_capture.
// Waveform lengths are in PCLK cycles; TIMEOUT is shortened so runs stay small.

module tb_pwm_capture;

    localparam int unsigned TB_TIMEOUT = 1500;
    localparam logic [31:0] TB_RESET_HIGH = 32'h0000_00A5;

    localparam logic [31:0] A_CTRL   = 32'h0000_0000;
    localparam logic [31:0] A_STATUS = 32'h0000_0004;
    localparam logic [31:0] A_HIGH   = 32'h0000_0008;
    localparam logic [31:0] A_PERIOD = 32'h0000_000C;
    localparam logic [31:0] A_OTHER  = 32'h0000_0108;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        pwm_in;
    logic        capture_irq;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_capture #(
        .TIMEOUT    (TB_TIMEOUT),
        .RESET_HIGH (TB_RESET_HIGH)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .pwm_in      (pwm_in),
        .capture_irq (capture_irq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int unsigned high;
        int unsigned period;
        logic [31:0] exp_high;
        logic [31:0] exp_period;
        logic [31:0] exp_status;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[5];

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = addr;
        PWDATA  = data;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = addr;
        tick();
        PENABLE = 1'b1;
        tick();
        data    = PRDATA;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] addr,
                              input logic [31:0] expected);
        logic [31:0] d;
        apb_read(addr, d);
        check(name, d, expected);
    endtask

    task automatic pwm_period(input int unsigned high, input int unsigned period);
        pwm_in = 1'b1;
        repeat (high) tick();
        pwm_in = 1'b0;
        repeat (period - high) tick();
    endtask

    // Disable, let the input settle low, clear STATUS, then enable with the given CTRL.
    task automatic restart(input logic [31:0] ctrl);
        apb_write(A_CTRL, 32'd0);
        pwm_in = 1'b0;
        repeat (4) tick();
        apb_write(A_STATUS, 32'h3);
        apb_write(A_CTRL, ctrl);
    endtask

    initial begin
        // high, period, HIGH, PERIOD, STATUS (VALID + ACTIVE in LOW_PH), irq
        vecs[0] = '{75, 1000, 32'd75, 32'd1000, 32'h5, 1'b1};
        vecs[1] = '{1,  2,    32'd1,  32'd2,    32'h5, 1'b1};
        vecs[2] = '{3,  7,    32'd3,  32'd7,    32'h5, 1'b1};
        vecs[3] = '{500, 1200, 32'd500, 32'd1200, 32'h5, 1'b1};
        vecs[4] = '{10, 11,   32'd10, 32'd11,   32'h5, 1'b1};

        PRESET  = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 32'd0;
        PWDATA  = 32'd0;
        pwm_in  = 1'b0;
        repeat (3) tick();
        PRESET = 1'b0;

        // Reset state
        check("reset_prdata", PRDATA, 32'd0);
        check("reset_irq", {31'd0, capture_irq}, 32'd0);
        check("pready", {31'd0, PREADY}, 32'd1);
        check("pslverr", {31'd0, PSLVERR}, 32'd0);
        read_check("reset_ctrl", A_CTRL, 32'd0);
        read_check("reset_status", A_STATUS, 32'd0);
        read_check("reset_high", A_HIGH, TB_RESET_HIGH);
        read_check("reset_period", A_PERIOD, 32'd0);
        read_check("unselected_block", A_OTHER, 32'd0);

        // Table: two full periods, a third rise, then low; reads land in LOW_PH
        for (int i = 0; i < 5; i++) begin
            restart(32'h3);
            pwm_period(vecs[i].high, vecs[i].period);
            pwm_period(vecs[i].high, vecs[i].period);
            pwm_in = 1'b1;
            repeat (vecs[i].high) tick();
            pwm_in = 1'b0;
            repeat (4) tick();
            read_check($sformatf("vec%0d_high", i), A_HIGH, vecs[i].exp_high);
            read_check($sformatf("vec%0d_period", i), A_PERIOD, vecs[i].exp_period);
            read_check($sformatf("vec%0d_status", i), A_STATUS, vecs[i].exp_status);
            check($sformatf("vec%0d_irq", i), {31'd0, capture_irq}, {31'd0, vecs[i].exp_irq});
        end
        read_check("ctrl_rw", A_CTRL, 32'h3);

        // W1C of pending VALID clears the interrupt
        apb_write(A_STATUS, 32'h1);
        read_check("w1c_status", A_STATUS, 32'h4);
        check("w1c_irq", {31'd0, capture_irq}, 32'd0);

        // W1C landing on the same edge as a capture: the capture wins.
        // pwm_in rising after edge X produces the capture at edge X+3, which is
        // the access edge of a write started one cycle later.
        pwm_in = 1'b1;
        tick();
        apb_write(A_STATUS, 32'h1);
        repeat (2) tick();
        read_check("w1c_vs_capture_status", A_STATUS, 32'h5);
        check("w1c_vs_capture_irq", {31'd0, capture_irq}, 32'd1);
        pwm_in = 1'b0;

        // First rise after enable gives no capture
        restart(32'h1);
        pwm_period(4, 9);
        repeat (2) tick();
        read_check("first_rise_no_capture", A_STATUS, 32'h4);

        // EN=0 written during HIGH_PH
        restart(32'h1);
        pwm_period(5, 12);
        pwm_period(5, 12);
        pwm_in = 1'b1;
        repeat (5) tick();
        read_check("high_ph_status", A_STATUS, 32'h5);
        apb_write(A_CTRL, 32'h0);
        read_check("disable_status", A_STATUS, 32'h1);
        read_check("disable_high", A_HIGH, 32'd5);
        read_check("disable_period", A_PERIOD, 32'd12);
        pwm_in = 1'b0;

        // Input stuck high past TIMEOUT
        restart(32'h3);
        pwm_period(20, 50);
        pwm_period(20, 50);
        pwm_in = 1'b1;
        repeat (TB_TIMEOUT + 50) tick();
        read_check("timeout_status", A_STATUS, 32'h3);
        read_check("timeout_high", A_HIGH, 32'd20);
        read_check("timeout_period", A_PERIOD, 32'd50);
        check("timeout_irq", {31'd0, capture_irq}, 32'd1);
        pwm_in = 1'b0;

        // Reset pulse in LOW_PH discards everything
        restart(32'h3);
        pwm_period(5, 12);
        pwm_period(5, 12);
        pwm_in = 1'b1;
        repeat (5) tick();
        pwm_in = 1'b0;
        repeat (4) tick();
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        check("rst2_irq", {31'd0, capture_irq}, 32'd0);
        check("rst2_prdata", PRDATA, 32'd0);
        read_check("rst2_ctrl", A_CTRL, 32'd0);
        read_check("rst2_status", A_STATUS, 32'd0);
        read_check("rst2_high", A_HIGH, TB_RESET_HIGH);
        read_check("rst2_period", A_PERIOD, 32'd0);
        apb_write(A_CTRL, 32'h1);
        pwm_period(4, 9);
        repeat (4) tick();
        read_check("rst2_one_rise", A_STATUS, 32'h4);
        pwm_in = 1'b1;
        repeat (4) tick();
        pwm_in = 1'b0;
        repeat (4) tick();
        read_check("rst2_two_rises", A_STATUS, 32'h5);
        read_check("rst2_high_cap", A_HIGH, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
